pipeline_sized_fifo: RTL and testbench

- Registered-output, multi-entry FIFO stage that sits directly downstream of the bypass FIFO stage in the multi-cycle rule/port plumbing.
- It takes that stage's dequeued value, its not-empty/dequeue pair drives this block's ENQ, and it buffers up to 2**logDepth entries for the consumer.
- It keeps the same per-round "consumed" bookkeeping (CONSUMED, CONSUMED_BEFORE, RESET), so the two stages compose without glue logic.
- Unlike the bypass stage, DEQ_VALUE is always a stored entry; enqueue-to-visible latency is one cycle.

---
 rtl/pipeline_sized_fifo_if.sv | 24 ++
 rtl/pipeline_sized_fifo.sv | 53 +++++
 tb/tb_pipeline_sized_fifo.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/pipeline_sized_fifo_if.sv
// pipeline_sized_fifo_if: enqueue, dequeue and round-bookkeeping bundle of the pipeline-sized FIFO
interface pipeline_sized_fifo_if #(
  parameter int width    = 0,
  parameter int logDepth = 1
);
  logic              enq;
  logic [width:0]    enq_value;
  logic              not_full;
  logic              consumed_before;
  logic              reset;
  logic              consumed;
  logic              not_empty;
  logic [width:0]    deq_value;
  logic              deq;
  logic [logDepth:0] count;
  modport master (
    output enq, enq_value, reset, deq,
    input  not_full, consumed_before, consumed, not_empty, deq_value, count
  );
  modport slave (
    input  enq, enq_value, reset, deq,
    output not_full, consumed_before, consumed, not_empty, deq_value, count
  );
endinterface

// File: rtl/pipeline_sized_fifo.sv
// pipeline_sized_fifo: registered-output FIFO of 2**logDepth entries with pipeline enqueue and per-round consumed flag
module pipeline_sized_fifo #(
  parameter int width    = 0,
  parameter int logDepth = 1
) (
  input logic                  clk,
  input logic                  rst_n,
  pipeline_sized_fifo_if.slave bus
);
  localparam int depth = 1 << logDepth;
  localparam logic [logDepth:0] full_cnt = {1'b1, {logDepth{1'b0}}};
  logic [width:0]      mem_q [depth];
  logic [logDepth-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [logDepth:0]   count_q, count_d;
  logic                consumed_q, consumed_d;
  logic                not_full, enq_ok, deq_ok;
  assign not_full            = (count_q != full_cnt) || bus.deq;
  assign bus.not_full        = not_full;
  assign bus.not_empty       = count_q != '0;
  assign bus.count           = count_q;
  assign bus.deq_value       = mem_q[rd_ptr_q];
  assign bus.consumed_before = consumed_q;
  assign bus.consumed        = bus.enq || consumed_q;
  // Next state: a full FIFO still accepts when the same cycle dequeues; RESET outranks ENQ for the round flag
  always_comb begin
    deq_ok     = bus.deq && count_q != '0;
    enq_ok     = bus.enq && not_full;
    wr_ptr_d   = enq_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = deq_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = (enq_ok && !deq_ok) ? count_q + 1'b1 :
                 (!enq_ok && deq_ok) ? count_q - 1'b1 : count_q;
    consumed_d = bus.reset ? 1'b0 : bus.enq ? 1'b1 : consumed_q;
  end
  // Control state with asynchronous discard of all entries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      consumed_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      consumed_q <= consumed_d;
    end
  end
  // Storage is never reset; a write lands in the slot just freed when full with a same-cycle dequeue
  always_ff @(posedge clk) begin
    if (enq_ok) mem_q[wr_ptr_q] <= bus.enq_value;
  end
  assert property (@(posedge clk) disable iff (!rst_n) count_q <= full_cnt);
endmodule

// File: tb/tb_pipeline_sized_fifo.sv
// tb_pipeline_sized_fifo: vector table, async-reset sequences and randomized queue-model check of pipeline_sized_fifo
module tb_pipeline_sized_fifo;
  logic clk = 1'b0, rst_n = 1'b1, enq = 1'b0, deq = 1'b0, rnd = 1'b0;
  logic [7:0] val = '0;
  int compared = 0, mismatched = 0;
  pipeline_sized_fifo_if #(.width(7), .logDepth(2)) ia ();
  pipeline_sized_fifo_if #(.width(7), .logDepth(1)) ib ();
  pipeline_sized_fifo_if #(.width(7), .logDepth(3)) ic ();
  pipeline_sized_fifo #(.width(7), .logDepth(2)) ua (.clk(clk), .rst_n(rst_n), .bus(ia));
  pipeline_sized_fifo #(.width(7), .logDepth(1)) ub (.clk(clk), .rst_n(rst_n), .bus(ib));
  pipeline_sized_fifo #(.width(7), .logDepth(3)) uc (.clk(clk), .rst_n(rst_n), .bus(ic));
  assign ia.enq = enq; assign ia.deq = deq; assign ia.reset = rnd; assign ia.enq_value = val;
  assign ib.enq = enq; assign ib.deq = deq; assign ib.reset = rnd; assign ib.enq_value = val;
  assign ic.enq = enq; assign ic.deq = deq; assign ic.reset = rnd; assign ic.enq_value = val;
  logic nf [3], ne [3], cs [3], cb [3];
  logic [7:0] dv [3];
  logic [3:0] cnt [3];
  assign nf[0] = ia.not_full;  assign nf[1] = ib.not_full;  assign nf[2] = ic.not_full;
  assign ne[0] = ia.not_empty; assign ne[1] = ib.not_empty; assign ne[2] = ic.not_empty;
  assign cs[0] = ia.consumed;  assign cs[1] = ib.consumed;  assign cs[2] = ic.consumed;
  assign cb[0] = ia.consumed_before; assign cb[1] = ib.consumed_before; assign cb[2] = ic.consumed_before;
  assign dv[0] = ia.deq_value; assign dv[1] = ib.deq_value; assign dv[2] = ic.deq_value;
  assign cnt[0] = {1'b0, ia.count}; assign cnt[1] = {2'b0, ib.count}; assign cnt[2] = ic.count;
  always #5 clk = ~clk;
  typedef struct {
    logic enq, deq, rnd;
    logic [7:0] val;
    int cnt;
    logic nf, ne, cons, cb;
    int dvm;
    logic [7:0] dv;
  } vec_t;
  vec_t tv [19];
  int dep [3] = '{4, 2, 8};
  logic [7:0] m [3][8];
  int n [3];
  bit cm [3];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic model_check(input int cyc);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rnd%0d_nf%0d", cyc, k), 32'(nf[k]), 32'((n[k] != dep[k]) || deq));
      chk($sformatf("rnd%0d_cnt%0d", cyc, k), 32'(cnt[k]), 32'(n[k]));
      chk($sformatf("rnd%0d_ne%0d", cyc, k), 32'(ne[k]), 32'(n[k] != 0));
      if (n[k] != 0) chk($sformatf("rnd%0d_dv%0d", cyc, k), 32'(dv[k]), 32'(m[k][0]));
      chk($sformatf("rnd%0d_cons%0d", cyc, k), 32'(cs[k]), 32'(enq || cm[k]));
      chk($sformatf("rnd%0d_cb%0d", cyc, k), 32'(cb[k]), 32'(cm[k]));
    end
  endtask
  task automatic model_step();
    bit d_ok, e_ok;
    for (int k = 0; k < 3; k++) begin
      d_ok = deq && n[k] > 0;
      e_ok = enq && (n[k] < dep[k] || deq);
      if (d_ok) begin
        for (int j = 0; j < 7; j++) m[k][j] = m[k][j+1];
        n[k]--;
      end
      if (e_ok) begin
        m[k][n[k]] = val;
        n[k]++;
      end
      cm[k] = rnd ? 1'b0 : enq ? 1'b1 : cm[k];
    end
  endtask
  initial begin
    //          enq deq rnd val    cnt nf ne cons cb dvm dv
    tv[0]  = '{1, 0, 0, 8'h11, 0, 1, 0, 1, 0, 0, 8'h00};
    tv[1]  = '{1, 0, 0, 8'h22, 1, 1, 1, 1, 1, 1, 8'h11};
    tv[2]  = '{1, 0, 0, 8'h33, 2, 1, 1, 1, 1, 1, 8'h11};
    tv[3]  = '{1, 0, 0, 8'h44, 3, 1, 1, 1, 1, 1, 8'h11};
    tv[4]  = '{1, 0, 0, 8'h55, 4, 0, 1, 1, 1, 1, 8'h11};
    tv[5]  = '{1, 1, 0, 8'h66, 4, 1, 1, 1, 1, 1, 8'h11};
    tv[6]  = '{0, 1, 0, 8'h00, 4, 1, 1, 1, 1, 1, 8'h22};
    tv[7]  = '{0, 1, 0, 8'h00, 3, 1, 1, 1, 1, 1, 8'h33};
    tv[8]  = '{0, 1, 0, 8'h00, 2, 1, 1, 1, 1, 1, 8'h44};
    tv[9]  = '{0, 1, 0, 8'h00, 1, 1, 1, 1, 1, 1, 8'h66};
    tv[10] = '{0, 0, 1, 8'h00, 0, 1, 0, 1, 1, 0, 8'h00};
    tv[11] = '{1, 1, 0, 8'hA5, 0, 1, 0, 1, 0, 2, 8'hA5};
    tv[12] = '{0, 0, 0, 8'h00, 1, 1, 1, 1, 1, 1, 8'hA5};
    tv[13] = '{0, 1, 0, 8'h00, 1, 1, 1, 1, 1, 1, 8'hA5};
    tv[14] = '{0, 0, 0, 8'h00, 0, 1, 0, 1, 1, 0, 8'h00};
    tv[15] = '{1, 0, 1, 8'h77, 0, 1, 0, 1, 1, 0, 8'h00};
    tv[16] = '{0, 0, 0, 8'h00, 1, 1, 1, 0, 0, 1, 8'h77};
    tv[17] = '{0, 1, 0, 8'h00, 1, 1, 1, 0, 0, 1, 8'h77};
    tv[18] = '{0, 0, 0, 8'h00, 0, 1, 0, 0, 0, 0, 8'h00};
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ne", 32'(ne[0]), 0);
    chk("rst_nf", 32'(nf[0]), 1);
    chk("rst_cnt", 32'(cnt[0]), 0);
    chk("rst_cb", 32'(cb[0]), 0);
    chk("rst_cons", 32'(cs[0]), 32'(enq));
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 19; i++) begin
      @(posedge clk);
      #1;
      enq = tv[i].enq; deq = tv[i].deq; rnd = tv[i].rnd; val = tv[i].val;
      @(negedge clk);
      chk($sformatf("row%0d_cnt", i), 32'(cnt[0]), 32'(tv[i].cnt));
      chk($sformatf("row%0d_nf", i), 32'(nf[0]), 32'(tv[i].nf));
      chk($sformatf("row%0d_ne", i), 32'(ne[0]), 32'(tv[i].ne));
      chk($sformatf("row%0d_cons", i), 32'(cs[0]), 32'(tv[i].cons));
      chk($sformatf("row%0d_cb", i), 32'(cb[0]), 32'(tv[i].cb));
      if (tv[i].dvm == 1) chk($sformatf("row%0d_dv", i), 32'(dv[0]), 32'(tv[i].dv));
      else if (tv[i].dvm == 2) begin
        compared++;
        if (dv[0] === tv[i].dv) begin
          mismatched++;
          $display("FAIL row%0d_nobypass: got %0h required anything but %0h", i, dv[0], tv[i].dv);
        end
      end
    end
    @(posedge clk);
    #1 enq = 1'b1; val = 8'h31;
    @(posedge clk);
    #1 val = 8'h32;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_ne", 32'(ne[0]), 0);
    chk("midrst_nf", 32'(nf[0]), 1);
    chk("midrst_cnt", 32'(cnt[0]), 0);
    chk("midrst_cb", 32'(cb[0]), 0);
    chk("midrst_cons", 32'(cs[0]), 1);
    enq = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_cnt", 32'(cnt[0]), 0);
    chk("postrst_ne", 32'(ne[0]), 0);
    for (int k = 0; k < 3; k++) begin
      n[k] = 0;
      cm[k] = 1'b0;
    end
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      if (i > 0) model_step();
      #1;
      enq = $urandom_range(0, 99) < (i < 500 ? 70 : 40);
      deq = $urandom_range(0, 99) < (i < 500 ? 40 : 70);
      rnd = $urandom_range(0, 99) < 10;
      val = 8'($urandom);
      @(negedge clk);
      model_check(i);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
